// File: rtl/mips_encode_pkg.sv
// Constants shared between the MIPS arithmetic decoder and this encoder:
// opcodes, funct codes, ALU control codes and the encoder FSM states.
package mips_encode_pkg;

    localparam logic [5:0] OP_OTHER0 = 6'h00;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_ANDI   = 6'h0c;
    localparam logic [5:0] OP_ORI    = 6'h0d;
    localparam logic [5:0] OP_XORI   = 6'h0e;

    localparam logic [5:0] OP0_ADD = 6'h20;
    localparam logic [5:0] OP0_SUB = 6'h22;
    localparam logic [5:0] OP0_AND = 6'h24;
    localparam logic [5:0] OP0_OR  = 6'h25;
    localparam logic [5:0] OP0_NOR = 6'h27;
    localparam logic [5:0] OP0_XOR = 6'h26;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_AND = 3'b100;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_NOR = 3'b110;
    localparam logic [2:0] ALU_XOR = 3'b111;

    localparam logic [1:0] SRC2_REG  = 2'b00;
    localparam logic [1:0] SRC2_SEXT = 2'b01;
    localparam logic [1:0] SRC2_ZEXT = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENC   = 2'd1,
        S_WRITE = 2'd2,
        S_FULL  = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0]  alu_op;
        logic        rd_src;
        logic [1:0]  alu_src2;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm;
    } enc_req_t;

endpackage

// File: rtl/mips_encode_word.sv
// Combinational encoder: decoded control tuple plus fields -> instruction word
// and a legality flag. Illegal tuples produce word 0.
module mips_encode_word
    import mips_encode_pkg::*;
(
    input  logic [2:0]  alu_op,
    input  logic        rd_src,
    input  logic [1:0]  alu_src2,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [15:0] imm,
    output logic [31:0] word,
    output logic        legal
);
    logic [5:0] funct;
    logic       funct_ok;
    logic [5:0] opc;
    logic       i_ok;

    always_comb begin
        funct    = 6'h00;
        funct_ok = 1'b1;
        case (alu_op)
            ALU_ADD: funct = OP0_ADD;
            ALU_SUB: funct = OP0_SUB;
            ALU_AND: funct = OP0_AND;
            ALU_OR:  funct = OP0_OR;
            ALU_NOR: funct = OP0_NOR;
            ALU_XOR: funct = OP0_XOR;
            default: funct_ok = 1'b0;
        endcase
    end

    // Only these four immediate forms exist; subi/nori and mismatched
    // extension kinds have no opcode.
    always_comb begin
        opc  = 6'h00;
        i_ok = 1'b1;
        case ({alu_src2, alu_op})
            {SRC2_SEXT, ALU_ADD}: opc = OP_ADDI;
            {SRC2_ZEXT, ALU_AND}: opc = OP_ANDI;
            {SRC2_ZEXT, ALU_OR}:  opc = OP_ORI;
            {SRC2_ZEXT, ALU_XOR}: opc = OP_XORI;
            default:              i_ok = 1'b0;
        endcase
    end

    always_comb begin
        word  = 32'h0;
        legal = 1'b0;
        if (!rd_src && alu_src2 == SRC2_REG && funct_ok) begin
            legal = 1'b1;
            word  = {OP_OTHER0, rs, rt, rd, 5'b00000, funct};
        end else if (rd_src && i_ok) begin
            legal = 1'b1;
            word  = {opc, rs, rt, imm};
        end
    end

endmodule

// File: rtl/mips_encode.sv
// Request handshake, encode/legality step and sequential image writer.
// One request in flight at a time: IDLE -> ENC -> WRITE (or back to IDLE).
module mips_encode
    import mips_encode_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        alu_op,
    input  logic              rd_src,
    input  logic [1:0]        alu_src2,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [15:0]       imm,
    input  logic              clear,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_data,
    output logic              except,
    output logic              full,
    output logic [ADDR_W:0]   word_count
);
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;

    state_t             state_q, state_d;
    enc_req_t           req_q, req_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W:0]    cnt_q, cnt_d;
    logic [31:0]        data_q, data_d;
    logic [31:0]        enc_word;
    logic               enc_legal;

    mips_encode_word u_word (
        .alu_op   (req_q.alu_op),
        .rd_src   (req_q.rd_src),
        .alu_src2 (req_q.alu_src2),
        .rs       (req_q.rs),
        .rt       (req_q.rt),
        .rd       (req_q.rd),
        .imm      (req_q.imm),
        .word     (enc_word),
        .legal    (enc_legal)
    );

    // Outputs decode straight from state so an async reset kills a write at once.
    assign in_ready   = reset && (state_q == S_IDLE);
    assign mem_we     = (state_q == S_WRITE) && !clear;
    assign except     = (state_q == S_ENC) && !enc_legal && !clear;
    assign full       = (state_q == S_FULL);
    assign mem_addr   = addr_q;
    assign mem_data   = data_q;
    assign word_count = cnt_q;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    req_d   = '{alu_op, rd_src, alu_src2, rs, rt, rd, imm};
                    state_d = S_ENC;
                end
            end
            S_ENC: begin
                if (enc_legal) begin
                    data_d  = enc_word;
                    state_d = S_WRITE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WRITE: begin
                cnt_d = cnt_q + CNT_ONE;
                if (addr_q == '1) begin
                    state_d = S_FULL;
                end else begin
                    addr_d  = addr_q + ADDR_ONE;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_FULL;
        endcase
        if (clear) begin
            state_d = S_IDLE;
            req_d   = req_q;
            addr_d  = '0;
            cnt_d   = '0;
            data_d  = data_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

endmodule
